ws2812_frame_ctrl: RTL and testbench

- Frame sequencer for the WS2812B chain.
- Walks a pixel buffer of `NUM_LEDS` 24-bit colours and hands each colour to the `send` serializer with a one-cycle start pulse.
- Waits for the serializer's per-LED completion, then holds the line idle for the latch gap (>50 µs) before reporting the frame complete.
- Sits between the pixel RAM (registered read) and `send`, and replaces free-running enable toggling with a handshaked, per-frame schedule.

---
 rtl/ws2812_frame_ctrl.sv | 156 +++++++++++++++
 tb/tb_ws2812_frame_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_ctrl.sv
`timescale 1ns / 1ps
// ws2812_frame_ctrl
// ----------------------------------------------------------------------------
// Frame sequencer for a WS2812B chain. On a frame request it walks the pixel
// buffer from address 0 to NUM_LEDS-1. For each LED it reads the registered
// pixel RAM, presents the colour to the bit serializer with a one-cycle start
// pulse, and waits for that LED's completion. After the last LED it holds the
// line idle for the latch gap, then pulses frame_done. A request arriving while
// a frame is in flight is remembered (one deep) and started right after.
//
// Ports
//   clk          system clock (25 MHz)
//   rst          synchronous, active-high reset
//   frame_req    request one frame; sampled every cycle
//   busy         high from frame acceptance through the end of the latch gap
//   frame_done   one-cycle pulse at the end of the latch gap
//   error        sticky serializer-timeout flag; cleared on the next accepted frame
//   pix_rd       pixel RAM read strobe
//   pix_addr     pixel index
//   pix_data     {green, red, blue}; valid the cycle after pix_rd
//   send_start   one-cycle start pulse to the serializer
//   red/green/blue  colour to the serializer; held from send_start to send_done
//   send_done    one-cycle pulse from the serializer after 24 bits
// ----------------------------------------------------------------------------
module ws2812_frame_ctrl #(
  parameter int NUM_LEDS       = 8,
  parameter int ADDR_W         = 3,
  parameter int LATCH_CYCLES   = 1500,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_req,
  output logic              busy,
  output logic              frame_done,
  output logic              error,
  output logic              pix_rd,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [23:0]       pix_data,
  output logic              send_start,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  input  logic              send_done
);

  localparam int LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_LEDS - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(LATCH_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DATA,
    SENDING,
    LATCH
  } state_t;

  state_t           state;
  logic             pending;
  logic [LAT_W-1:0] lat_cnt;
  logic [TO_W-1:0]  to_cnt;

  // NOTE: every register here is updated with non-blocking assignments so all
  // state moves together on the edge and reads in this block see old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= 1'b0;
      lat_cnt    <= '0;
      to_cnt     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;
      pix_rd     <= 1'b0;
      pix_addr   <= '0;
      send_start <= 1'b0;
      red        <= '0;
      green      <= '0;
      blue       <= '0;
    end else begin
      // Single-cycle strobes default low and are raised only by the state
      // that owns them.
      frame_done <= 1'b0;
      send_start <= 1'b0;

      // Requests during a frame collapse into one remembered request.
      if (frame_req && busy) pending <= 1'b1;

      case (state)
        IDLE: begin
          if (frame_req || pending) begin
            state    <= FETCH;
            pix_addr <= '0;
            pix_rd   <= 1'b1;
            busy     <= 1'b1;
            error    <= 1'b0;
            pending  <= 1'b0;
          end
        end

        // The RAM samples pix_rd/pix_addr on this edge; data arrives next cycle.
        FETCH: begin
          pix_rd <= 1'b0;
          state  <= WAIT_DATA;
        end

        WAIT_DATA: begin
          green      <= pix_data[23:16];
          red        <= pix_data[15:8];
          blue       <= pix_data[7:0];
          send_start <= 1'b1;
          to_cnt     <= '0;
          state      <= SENDING;
        end

        SENDING: begin
          if (send_done) begin
            if (pix_addr == LAST_ADDR) begin
              lat_cnt <= '0;
              state   <= LATCH;
            end else begin
              pix_addr <= pix_addr + 1'b1;
              pix_rd   <= 1'b1;
              state    <= FETCH;
            end
          end else if (to_cnt == TO_LAST) begin
            // Serializer stalled: abandon the remaining LEDs but still honour
            // the latch gap so the chain sees a clean frame boundary.
            error   <= 1'b1;
            lat_cnt <= '0;
            state   <= LATCH;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        LATCH: begin
          if (lat_cnt == LAT_LAST) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
`timescale 1ns / 1ps
// Bench for ws2812_frame_ctrl: a 3-LED instance (dut_a) exercises the frame
// walk, request merging, timeout, reset and spurious-done cases; a 1-LED
// instance (dut_b) covers the single-LED boundary. Expected colours are queued
// when a frame is requested and popped as send_start pulses appear.
module tb_ws2812_frame_ctrl;

  localparam int LATCH = 1500;
  localparam int TMO   = 4096;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic rst;

  // 3-LED instance
  logic        frame_req_a, busy_a, frame_done_a, error_a, pix_rd_a;
  logic [2:0]  pix_addr_a;
  logic [23:0] pix_data_a;
  logic        send_start_a, send_done_a, force_done_a;
  logic [7:0]  red_a, green_a, blue_a;

  // 1-LED instance
  logic        frame_req_b, busy_b, frame_done_b, error_b, pix_rd_b;
  logic [0:0]  pix_addr_b;
  logic [23:0] pix_data_b;
  logic        send_start_b, send_done_b;
  logic [7:0]  red_b, green_b, blue_b;

  ws2812_frame_ctrl #(
    .NUM_LEDS(3), .ADDR_W(3), .LATCH_CYCLES(LATCH), .TIMEOUT_CYCLES(TMO)
  ) dut_a (
    .clk(clk), .rst(rst), .frame_req(frame_req_a), .busy(busy_a),
    .frame_done(frame_done_a), .error(error_a), .pix_rd(pix_rd_a),
    .pix_addr(pix_addr_a), .pix_data(pix_data_a), .send_start(send_start_a),
    .red(red_a), .green(green_a), .blue(blue_a), .send_done(send_done_a)
  );

  ws2812_frame_ctrl #(
    .NUM_LEDS(1), .ADDR_W(1), .LATCH_CYCLES(LATCH), .TIMEOUT_CYCLES(TMO)
  ) dut_b (
    .clk(clk), .rst(rst), .frame_req(frame_req_b), .busy(busy_b),
    .frame_done(frame_done_b), .error(error_b), .pix_rd(pix_rd_b),
    .pix_addr(pix_addr_b), .pix_data(pix_data_b), .send_start(send_start_b),
    .red(red_b), .green(green_b), .blue(blue_b), .send_done(send_done_b)
  );

  // ---------------- stimulus table and scoreboard ----------------
  typedef struct {
    logic [23:0] pix;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } vec_t;

  vec_t vecs [3];
  vec_t exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- pixel RAMs (registered read) ----------------
  logic [23:0] ram_a [4];
  logic [23:0] ram_b [2];

  always @(posedge clk) begin
    if (pix_rd_a) pix_data_a <= ram_a[pix_addr_a];
    if (pix_rd_b) pix_data_b <= ram_b[pix_addr_b];
  end

  // ---------------- serializer models ----------------
  // send_done is raised send_delay cycles after the send_start cycle, unless
  // the start index matches hang_at, in which case it never comes.
  logic [1:0] sst;
  logic [1:0] model_done;
  int rem [2];
  int model_starts [2] = '{0, 0};
  int hang_at [2]      = '{-1, -1};
  int send_delay       = 720;

  assign sst         = {send_start_b, send_start_a};
  assign send_done_a = model_done[0] | force_done_a;
  assign send_done_b = model_done[1];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        rem[k]        <= 0;
        model_done[k] <= 1'b0;
      end else if (sst[k]) begin
        model_done[k]   <= 1'b0;
        rem[k]          <= (model_starts[k] == hang_at[k]) ? 0 : send_delay - 1;
        model_starts[k] <= model_starts[k] + 1;
      end else begin
        model_done[k] <= (rem[k] == 1);
        if (rem[k] != 0) rem[k] <= rem[k] - 1;
      end
    end
  end

  // ---------------- cycle counter and monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   a_starts = 0, a_dones = 0, a_frames = 0;
  int   rd_rise_cyc = 0, done_a_cyc = 0, last_start_a_cyc = 0, err_a_cyc = 0;
  logic rd_prev = 1'b0, err_prev = 1'b0, sst_prev = 1'b0, gap_armed = 1'b0;
  int   b_starts = 0, done_b_cyc = 0;
  logic addr_b_bad = 1'b0;

  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      if (pix_rd_a && !rd_prev) rd_rise_cyc = cyc;
      rd_prev = pix_rd_a;
      if (send_start_a) begin
        a_starts++;
        last_start_a_cyc = cyc;
        check("send_start width", sst_prev, 1'b0);
        check("send_start after pix_rd", cyc - rd_rise_cyc, 2);
        if (exp_q.size() == 0) begin
          check("unexpected send_start", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("colour", {red_a, green_a, blue_a}, {e.r, e.g, e.b});
        end
        if (gap_armed) begin
          check("led-to-led gap", cyc - done_a_cyc, 3);
          gap_armed = 1'b0;
        end
      end
      sst_prev = send_start_a;
      if (model_done[0]) begin
        done_a_cyc = cyc;
        a_dones++;
        gap_armed = 1'b1;
      end
      if (frame_done_a) a_frames++;
      if (error_a && !err_prev) err_a_cyc = cyc;
      err_prev = error_a;
      if (!busy_a) gap_armed = 1'b0;
      if (pix_addr_a > 3'd2) check("pix_addr range", pix_addr_a, 2);
      if (send_start_b) b_starts++;
      if (model_done[1]) done_b_cyc = cyc;
      if (pix_addr_b != 1'b0) addr_b_bad = 1'b1;
    end
  end

  // ---------------- helpers ----------------
  task automatic pulse_req(input int which);
    if (which == 0) frame_req_a = 1'b1;
    else            frame_req_b = 1'b1;
    @(negedge clk);
    frame_req_a = 1'b0;
    frame_req_b = 1'b0;
  endtask

  task automatic push_frame(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(vecs[i]);
  endtask

  task automatic wait_fd(input int which, input int budget, input string name);
    logic seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = (which == 0) ? frame_done_a : frame_done_b;
    end
    check(name, seen, 1'b1);
  endtask

  task automatic wait_a_count(input int base, input int need, input logic dones,
                              input string name);
    logic ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      ok = ((dones ? a_dones : a_starts) - base) >= need;
    end
    check(name, ok, 1'b1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base, base2;

    vecs[0] = '{pix: 24'h00FF00, r: 8'hFF, g: 8'h00, b: 8'h00};
    vecs[1] = '{pix: 24'h0000FF, r: 8'h00, g: 8'h00, b: 8'hFF};
    vecs[2] = '{pix: 24'hFF0000, r: 8'h00, g: 8'hFF, b: 8'h00};
    for (int i = 0; i < 3; i++) ram_a[i] = vecs[i].pix;
    ram_a[3] = 24'h0;
    ram_b[0] = 24'h123456;
    ram_b[1] = 24'h0;

    rst = 1'b1; frame_req_a = 1'b0; frame_req_b = 1'b0; force_done_a = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst busy", busy_a, 1'b0);
    check("rst frame_done", frame_done_a, 1'b0);
    check("rst error", error_a, 1'b0);
    check("rst pix_rd", pix_rd_a, 1'b0);
    check("rst pix_addr", pix_addr_a, 0);
    check("rst send_start", send_start_a, 1'b0);
    check("rst colour", {red_a, green_a, blue_a}, 0);
    check("rst busy b", busy_b, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Single frame, 720-cycle serializer
    send_delay = 720;
    push_frame(3);
    base = a_starts;
    pulse_req(0);
    check("t1 busy after accept", busy_a, 1'b1);
    check("t1 pix_rd after accept", pix_rd_a, 1'b1);
    check("t1 pix_addr first", pix_addr_a, 0);
    @(negedge clk);
    check("t1 pix_rd one cycle", pix_rd_a, 1'b0);
    check("t1 no early start", send_start_a, 1'b0);
    @(negedge clk);
    check("t1 first send_start", send_start_a, 1'b1);
    wait_fd(0, 5000, "t1 frame_done seen");
    // Latch counter runs 0..LATCH-1 in the cycles after the done cycle.
    check("t1 latch gap", cyc - done_a_cyc, LATCH + 1);
    check("t1 start count", a_starts - base, 3);
    check("t1 busy falls with frame_done", busy_a, 1'b0);
    @(negedge clk);
    check("t1 frame_done one cycle", frame_done_a, 1'b0);
    check("t1 scoreboard drained", exp_q.size(), 0);

    // Back-to-back: two extra requests during frame 1 merge into one frame
    send_delay = 100;
    push_frame(3);
    push_frame(3);
    base  = a_starts;
    base2 = a_frames;
    pulse_req(0);
    repeat (200) @(negedge clk);
    pulse_req(0);
    repeat (600) @(negedge clk);
    pulse_req(0);
    wait_fd(0, 5000, "t2 first frame_done");
    check("t2 busy low between frames", busy_a, 1'b0);
    @(negedge clk);
    check("t2 restart busy", busy_a, 1'b1);
    check("t2 restart pix_rd", pix_rd_a, 1'b1);
    check("t2 restart addr", pix_addr_a, 0);
    wait_fd(0, 5000, "t2 second frame_done");
    repeat (20) @(negedge clk);
    check("t2 no third frame", busy_a, 1'b0);
    check("t2 frame count", a_frames - base2, 2);
    check("t2 start count", a_starts - base, 6);
    check("t2 scoreboard drained", exp_q.size(), 0);

    // Timeout on LED 1
    hang_at[0] = model_starts[0] + 1;
    exp_q.push_back(vecs[0]);
    exp_q.push_back(vecs[1]);
    base = a_starts;
    pulse_req(0);
    wait_fd(0, 8000, "t3 frame_done seen");
    check("t3 error timing", err_a_cyc - last_start_a_cyc, TMO);
    check("t3 latch after timeout", cyc - err_a_cyc, LATCH);
    check("t3 start count", a_starts - base, 2);
    check("t3 error sticky", error_a, 1'b1);
    hang_at[0] = -1;
    push_frame(3);
    pulse_req(0);
    check("t3 error cleared on accept", error_a, 1'b0);
    wait_fd(0, 5000, "t3 recovery frame_done");
    check("t3 error stays clear", error_a, 1'b0);

    // Reset while LED 1 is being sent
    send_delay = 720;
    exp_q.push_back(vecs[0]);
    exp_q.push_back(vecs[1]);
    base = a_starts;
    pulse_req(0);
    wait_a_count(base, 2, 1'b0, "t4 reached LED 1");
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4 busy", busy_a, 1'b0);
    check("t4 send_start", send_start_a, 1'b0);
    check("t4 pix_addr", pix_addr_a, 0);
    check("t4 pix_rd", pix_rd_a, 1'b0);
    check("t4 colour", {red_a, green_a, blue_a}, 0);
    repeat (5) @(negedge clk);
    check("t4 stays idle", busy_a, 1'b0);
    send_delay = 100;
    push_frame(3);
    pulse_req(0);
    check("t4 restart addr", pix_addr_a, 0);
    check("t4 restart pix_rd", pix_rd_a, 1'b1);
    wait_fd(0, 5000, "t4 restart frame_done");

    // Spurious send_done in IDLE
    force_done_a = 1'b1;
    @(negedge clk);
    force_done_a = 1'b0;
    check("t5 idle busy", busy_a, 1'b0);
    check("t5 idle pix_rd", pix_rd_a, 1'b0);
    check("t5 idle send_start", send_start_a, 1'b0);
    check("t5 idle addr", pix_addr_a, 2);
    check("t5 idle colour", {red_a, green_a, blue_a}, {vecs[2].r, vecs[2].g, vecs[2].b});
    repeat (3) @(negedge clk);
    check("t5 idle no frame", busy_a, 1'b0);

    // Spurious send_done in LATCH
    push_frame(3);
    base  = a_dones;
    base2 = a_starts;
    pulse_req(0);
    wait_a_count(base, 3, 1'b1, "t5 reached latch");
    repeat (100) @(negedge clk);
    force_done_a = 1'b1;
    @(negedge clk);
    force_done_a = 1'b0;
    check("t5 latch busy", busy_a, 1'b1);
    check("t5 latch pix_rd", pix_rd_a, 1'b0);
    check("t5 latch send_start", send_start_a, 1'b0);
    check("t5 latch addr", pix_addr_a, 2);
    wait_fd(0, 3000, "t5 frame_done seen");
    check("t5 latch gap intact", cyc - done_a_cyc, LATCH + 1);
    check("t5 start count", a_starts - base2, 3);

    // NUM_LEDS = 1
    base = b_starts;
    pulse_req(1);
    check("t6 pix_rd", pix_rd_b, 1'b1);
    check("t6 addr", pix_addr_b, 0);
    @(negedge clk);
    @(negedge clk);
    check("t6 send_start", send_start_b, 1'b1);
    check("t6 colour", {red_b, green_b, blue_b}, 24'h341256);
    wait_fd(1, 3000, "t6 frame_done seen");
    check("t6 start count", b_starts - base, 1);
    check("t6 latch direct", cyc - done_b_cyc, LATCH + 1);
    check("t6 addr stayed 0", addr_b_bad, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(40 * 90000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

endmodule
